// File: rtl/prim_credit_pkg.sv
// rtl/prim_credit_pkg.sv - shared types and helpers for the credit sender
// Credit command encoding plus the saturating next-count function used by prim_credit_cnt.
package prim_credit_pkg;

  typedef enum logic [1:0] {
    CrNone,
    CrDec,
    CrInc,
    CrHold
  } credit_cmd_e;

  // Bits needed to hold values 0..value-1 (at least one bit).
  function automatic int unsigned vbits(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic logic [31:0] credit_next(input logic [31:0] cnt,
                                              input credit_cmd_e cmd,
                                              input logic [31:0] limit);
    logic [31:0] nxt;
    nxt = cnt;
    case (cmd)
      CrDec:   nxt = (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
      CrInc:   nxt = (cnt >= limit) ? limit : cnt + 32'd1;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/prim_credit_cnt.sv
// rtl/prim_credit_cnt.sv - saturating credit counter with clear and overflow flag
// Resets and clears to Max; ovf_o flags an increment attempted while already at Max.
module prim_credit_cnt
  import prim_credit_pkg::*;
#(
  parameter int unsigned Width = 3,
  parameter int unsigned Max   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             ovf_o
);

  credit_cmd_e      cmd;
  logic [Width-1:0] cnt_q;
  logic [31:0]      nxt;
  logic             unused_nxt;

  always_comb begin
    cmd = CrNone;
    if (dec_i && inc_i) begin
      cmd = CrHold;
    end else if (dec_i) begin
      cmd = CrDec;
    end else if (inc_i) begin
      cmd = CrInc;
    end
  end

  assign nxt        = credit_next(32'(cnt_q), cmd, 32'(Max));
  assign unused_nxt = ^nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= Width'(Max);
    end else if (clr_i) begin
      cnt_q <= Width'(Max);
    end else begin
      cnt_q <= nxt[Width-1:0];
    end
  end

  // A clear takes priority, so an increment in a clear cycle is not an overflow.
  assign ovf_o = ~clr_i & (cmd == CrInc) & (cnt_q == Width'(Max));
  assign cnt_o = cnt_q;

  always @(posedge clk_i) begin
    if (rst_ni && !clr_i) begin
      assert (!((cmd == CrDec) && (cnt_q == '0)));
    end
  end

endmodule

// File: rtl/prim_credit_sender.sv
// rtl/prim_credit_sender.sv - credit-based transmit end for a remote prim_fifo_sync
// Optional registered tx path: define PRIM_CREDIT_SENDER_OUTREG_EN.
module prim_credit_sender
  import prim_credit_pkg::*;
#(
  parameter int unsigned Width   = 16,
  parameter int unsigned Credits = 4,
  localparam int unsigned CntW   = vbits(Credits + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             tx_valid_o,
  output logic [Width-1:0] tx_data_o,
  input  logic             credit_ret_i,
  output logic [CntW-1:0]  credits_o,
  output logic             idle_o,
  output logic             err_o
);

  logic under_rst_q;
  logic err_q;
  logic send;
  logic tx_fire;
  logic cnt_ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      under_rst_q <= 1'b1;
    end else begin
      under_rst_q <= 1'b0;
    end
  end

  // Ready depends only on registered state, so a credit return shows up next cycle.
  assign wready_o = (credits_o != '0) & ~under_rst_q;
  assign send     = wvalid_i & wready_o;
  assign tx_fire  = send & ~clr_i;

  prim_credit_cnt #(
    .Width (CntW),
    .Max   (Credits)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .dec_i  (send),
    .inc_i  (credit_ret_i),
    .cnt_o  (credits_o),
    .ovf_o  (cnt_ovf)
  );

  // Sticky until reset; a clear leaves it set so the fault stays visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | cnt_ovf;
    end
  end

`ifdef PRIM_CREDIT_SENDER_OUTREG_EN
  logic             tx_valid_q;
  logic [Width-1:0] tx_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= tx_fire;
      if (tx_fire) begin
        tx_data_q <= wdata_i;
      end
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
`else
  assign tx_valid_o = tx_fire;
  assign tx_data_o  = wdata_i;
`endif

  assign idle_o = (credits_o == CntW'(Credits)) & ~tx_valid_o;
  assign err_o  = err_q;

endmodule

// File: tb/tb_prim_credit_sender.sv
// tb/tb_prim_credit_sender.sv - randomized self-checking bench for prim_credit_sender
// Reference: credit arithmetic model plus a queue-based remote FIFO in closed loop.
module tb_prim_credit_sender;

  localparam int W = 16;
  localparam int C = 4;
`ifdef PRIM_CREDIT_SENDER_OUTREG_EN
  localparam bit OutReg = 1'b1;
`else
  localparam bit OutReg = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clr = 1'b0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [W-1:0] wdata = '0;
  logic         tx_valid;
  logic [W-1:0] tx_data;
  logic         credit_ret = 1'b0;
  logic [2:0]   credits;
  logic         idle;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0]   m_cred;
  bit           m_under;
  bit           m_err;
  bit           m_txv;
  logic [W-1:0] m_txd;

  always #5 clk = ~clk;

  prim_credit_sender #(.Width(W), .Credits(C)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .wvalid_i     (wvalid),
    .wready_o     (wready),
    .wdata_i      (wdata),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .credit_ret_i (credit_ret),
    .credits_o    (credits),
    .idle_o       (idle),
    .err_o        (err)
  );

  function automatic bit exp_ready();
    return (m_cred != 3'd0) && !m_under;
  endfunction

  function automatic bit exp_txv();
    return OutReg ? m_txv : (wvalid && exp_ready() && !clr);
  endfunction

  function automatic logic [W-1:0] exp_txd();
    return OutReg ? m_txd : wdata;
  endfunction

  // Advance the model by one clock using the inputs present now, then move past the edge.
  task automatic tick();
    bit snd;
    snd = wvalid && exp_ready();
    if (clr) begin
      m_cred = 3'(C);
      m_txv  = 1'b0;
    end else begin
      if (snd && !credit_ret) m_cred = m_cred - 3'd1;
      else if (credit_ret && !snd) begin
        if (m_cred == 3'(C)) m_err = 1'b1;
        else m_cred = m_cred + 3'd1;
      end
      m_txv = snd;
      if (snd) m_txd = wdata;
    end
    m_under = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cred = 3'(C); m_under = 1'b1; m_err = 1'b0; m_txv = 1'b0; m_txd = '0;
  endtask

  task automatic apply_reset();
    clr = 0; wvalid = 0; credit_ret = 0; wdata = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tick();
  endtask

  task automatic drive_returns(input int n);
    wvalid = 0;
    credit_ret = 1;
    repeat (n) begin @(negedge clk); tick(); end
    credit_ret = 0;
  endtask

  task automatic test_reset();
    clr = 0; wvalid = 0; credit_ret = 0; wdata = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL reset_credits: got %0d expected %0d", credits, m_cred); end
    vectors++; if (wready !== 1'b0) begin miscompares++; $display("FAIL reset_wready: got %b expected 0", wready); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (tx_data !== '0) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b expected 1", idle); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (wready !== 1'b0) begin miscompares++; $display("FAIL release_cycle0_wready: got %b expected 0", wready); end
    tick();
    @(negedge clk);
    vectors++; if (wready !== 1'b1) begin miscompares++; $display("FAIL release_cycle1_wready: got %b expected 1", wready); end
    vectors++; if (credits !== 3'(C)) begin miscompares++; $display("FAIL release_cycle1_credits: got %0d expected %0d", credits, C); end
    tick();
  endtask

  task automatic test_burst();
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      wvalid = 1'b1;
      wdata  = W'($urandom);
      @(negedge clk);
      vectors++; if (wready !== exp_ready()) begin miscompares++; $display("FAIL burst_wready[%0d]: got %b expected %b", i, wready, exp_ready()); end
      vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL burst_credits[%0d]: got %0d expected %0d", i, credits, m_cred); end
      vectors++; if (tx_valid !== exp_txv()) begin miscompares++; $display("FAIL burst_tx_valid[%0d]: got %b expected %b", i, tx_valid, exp_txv()); end
      vectors++; if (tx_data !== exp_txd()) begin miscompares++; $display("FAIL burst_tx_data[%0d]: got %h expected %h", i, tx_data, exp_txd()); end
      if (i >= 4) begin
        vectors++; if (wready !== 1'b0) begin miscompares++; $display("FAIL burst_starved[%0d]: got %b expected 0", i, wready); end
      end
      if (tx_valid === 1'b1) pulses++;
      tick();
    end
    wvalid = 1'b0;
    @(negedge clk);
    if (tx_valid === 1'b1) pulses++;
    vectors++; if (pulses != 4) begin miscompares++; $display("FAIL burst_send_count: got %0d expected 4", pulses); end
    vectors++; if (credits !== 3'd0) begin miscompares++; $display("FAIL burst_empty_credits: got %0d expected 0", credits); end
    vectors++; if (tx_data !== exp_txd()) begin miscompares++; $display("FAIL burst_tx_data_hold: got %h expected %h", tx_data, exp_txd()); end
    tick();
    drive_returns(C);
    @(negedge clk);
    vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL burst_refill: got %0d expected %0d", credits, m_cred); end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    wvalid = 1'b1;
    repeat (2) begin wdata = W'($urandom); @(negedge clk); tick(); end
    wvalid = 1'b0;
    @(negedge clk); tick();
    wvalid = 1'b1; credit_ret = 1'b1; wdata = W'($urandom);
    @(negedge clk);
    vectors++; if (credits !== 3'd2) begin miscompares++; $display("FAIL simul_start_credits: got %0d expected 2", credits); end
    if (tx_valid === 1'b1) pulses++;
    tick();
    wvalid = 1'b0; credit_ret = 1'b0;
    @(negedge clk);
    vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL simul_credits: got %0d expected %0d", credits, m_cred); end
    vectors++; if (tx_data !== exp_txd()) begin miscompares++; $display("FAIL simul_tx_data: got %h expected %h", tx_data, exp_txd()); end
    if (tx_valid === 1'b1) pulses++;
    tick();
    @(negedge clk);
    if (tx_valid === 1'b1) pulses++;
    vectors++; if (pulses != 1) begin miscompares++; $display("FAIL simul_tx_pulses: got %0d expected 1", pulses); end
    tick();
    drive_returns(2);
  endtask

  task automatic test_overflow();
    credit_ret = 1'b1;
    @(negedge clk); tick();
    credit_ret = 1'b0;
    @(negedge clk);
    vectors++; if (err !== m_err) begin miscompares++; $display("FAIL ovf_err: got %b expected %b", err, m_err); end
    vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL ovf_credits: got %0d expected %0d", credits, m_cred); end
    tick();
    clr = 1'b1;
    @(negedge clk); tick();
    clr = 1'b0;
    @(negedge clk);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ovf_err_after_clr: got %b expected 1", err); end
    vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL ovf_credits_after_clr: got %0d expected %0d", credits, m_cred); end
    tick();
  endtask

  task automatic test_clear();
    apply_reset();
    wvalid = 1'b1;
    repeat (3) begin wdata = W'($urandom); @(negedge clk); tick(); end
    wvalid = 1'b0;
    @(negedge clk); tick();
    wvalid = 1'b1; clr = 1'b1; wdata = W'($urandom);
    @(negedge clk);
    vectors++; if (credits !== 3'd1) begin miscompares++; $display("FAIL clr_pre_credits: got %0d expected 1", credits); end
    vectors++; if (tx_valid !== exp_txv()) begin miscompares++; $display("FAIL clr_same_cycle_tx_valid: got %b expected %b", tx_valid, exp_txv()); end
    tick();
    wvalid = 1'b0; clr = 1'b0;
    @(negedge clk);
    vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL clr_credits: got %0d expected %0d", credits, m_cred); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL clr_tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (tx_data !== exp_txd()) begin miscompares++; $display("FAIL clr_tx_data: got %h expected %h", tx_data, exp_txd()); end
    tick();
  endtask

  task automatic test_mid_reset();
    wvalid = 1'b1; wdata = W'($urandom);
    @(negedge clk); tick();
    rst_n = 1'b0;
    model_reset();
    #2;
    vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL midrst_credits: got %0d expected %0d", credits, m_cred); end
    vectors++; if (wready !== 1'b0) begin miscompares++; $display("FAIL midrst_wready: got %b expected 0", wready); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_tx_valid: got %b expected 0", tx_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b expected 0", err); end
    wvalid = 1'b0;
    apply_reset();
  endtask

  task automatic test_closed_loop();
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] sent_q[$];
    logic [W-1:0] got;
    bit full_before;
    apply_reset();
    for (int cyc = 0; cyc < 612; cyc++) begin
      if (cyc < 600) begin
        wvalid = ($urandom_range(0, 3) != 0);
        wdata  = W'($urandom);
      end else begin
        wvalid = 1'b0;
      end
      credit_ret = (fifo_q.size() != 0) && (cyc >= 600 || $urandom_range(0, 1) == 1);
      @(negedge clk);
      vectors++;
      if (int'(credits) + fifo_q.size() + (OutReg ? int'(tx_valid) : 0) != C) begin
        miscompares++; $display("FAIL loop_invariant[%0d]: credits %0d fifo %0d tx_valid %b sum expected %0d", cyc, credits, fifo_q.size(), tx_valid, C);
      end
      vectors++; if (credits !== m_cred) begin miscompares++; $display("FAIL loop_credits[%0d]: got %0d expected %0d", cyc, credits, m_cred); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL loop_err[%0d]: got %b expected 0", cyc, err); end
      full_before = (fifo_q.size() >= C);
      if (credit_ret) begin
        got = fifo_q.pop_front();
        vectors++;
        if (sent_q.size() == 0) begin
          miscompares++; $display("FAIL loop_order[%0d]: got %h expected no word", cyc, got);
        end else if (got !== sent_q[0]) begin
          miscompares++; $display("FAIL loop_order[%0d]: got %h expected %h", cyc, got, sent_q[0]);
        end
        if (sent_q.size() != 0) void'(sent_q.pop_front());
      end
      if (tx_valid === 1'b1) begin
        vectors++;
        if (full_before) begin
          miscompares++; $display("FAIL loop_overflow[%0d]: got push into full fifo expected none", cyc);
        end else begin
          fifo_q.push_back(tx_data);
        end
      end
      if (wvalid && exp_ready()) sent_q.push_back(wdata);
      tick();
    end
    credit_ret = 1'b0;
    @(negedge clk);
    vectors++; if (credits !== 3'(C)) begin miscompares++; $display("FAIL loop_final_credits: got %0d expected %0d", credits, C); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL loop_final_idle: got %b expected 1", idle); end
    vectors++; if (sent_q.size() != 0) begin miscompares++; $display("FAIL loop_undelivered: got %0d words left expected 0", sent_q.size()); end
    tick();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_mid_reset();
    test_closed_loop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
